fetch_stage: RTL and testbench

// Instruction fetch front end that produces the decode-stage input bundle
// (decode_valid/decode_pc/decode_inst) and honours decode_stall.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_skid_reg.sv | 56 +++++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared constants and types for the instruction fetch front end.
//   INST_NOP       : instruction presented to decode when the slot is empty
//   fetch_state_t  : fetch FSM encoding (EMPTY / FETCH / HOLD)
//   word_align     : clears the byte-offset bits of a 16-bit address
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // EMPTY: nothing in flight, skid empty.
    // FETCH: one read in flight, imem_rdata valid this cycle.
    // HOLD : skid full, nothing in flight.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    function automatic logic [15:0] word_align(input logic [15:0] addr);
        return addr & 16'hFFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// ---------------------------------------------------------------------------
// fetch_skid_reg
// One-entry {pc, inst} holding register used to park a response that decode
// could not accept.
//   clk        in   clock
//   rst        in   synchronous active-high reset (empties the entry)
//   load       in   capture load_pc/load_inst, mark valid
//   clear      in   drop the entry (wins over load)
//   load_pc    in   PC to capture
//   load_inst  in   instruction to capture
//   valid      out  entry holds a live instruction
//   pc         out  stored PC
//   inst       out  stored instruction (INST_NOP when empty)
// ---------------------------------------------------------------------------
module fetch_skid_reg
    import fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                clear,
    input  logic [PC_WIDTH-1:0] load_pc,
    input  logic [31:0]         load_inst,
    output logic                valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         inst
);

    logic                valid_r;
    logic [PC_WIDTH-1:0] pc_r;
    logic [31:0]         inst_r;

    // Entry storage: clear beats load so a redirect always empties the skid.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_r <= 1'b0;
            pc_r    <= '0;
            inst_r  <= INST_NOP;
        end else if (load) begin
            valid_r <= 1'b1;
            pc_r    <= load_pc;
            inst_r  <= load_inst;
        end else begin
            valid_r <= valid_r;
            pc_r    <= pc_r;
            inst_r  <= inst_r;
        end
    end

    assign valid = valid_r;
    assign pc    = pc_r;
    assign inst  = inst_r;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch front end. Issues word-aligned reads to a synchronous
// instruction memory (1-cycle latency), presents {pc, inst} to decode,
// parks one stalled response in a skid register and redirects on a taken
// branch/jump.
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   imem_req        out  read strobe, imem_addr valid this cycle
//   imem_addr       out  word-aligned read address
//   imem_rdata      in   data for the address issued the previous cycle
//   redirect_valid  in   taken branch/jump: squash slot and refetch
//   redirect_pc     in   redirect target, bits [1:0] ignored
//   decode_stall    in   decode did not consume the presented slot
//   decode_valid    out  presented slot holds a live instruction
//   decode_pc       out  PC of the presented instruction
//   decode_inst     out  presented instruction, INST_NOP when not valid
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                decode_stall,
    output logic                decode_valid,
    output logic [PC_WIDTH-1:0] decode_pc,
    output logic [31:0]         decode_inst
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(3));
    localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

    fetch_state_t        state_r;
    logic [PC_WIDTH-1:0] fetch_pc_r;
    logic [PC_WIDTH-1:0] inflight_pc_r;

    logic                issue_s;
    logic [PC_WIDTH-1:0] issue_addr_s;
    logic                skid_load_s;
    logic                skid_valid_s;
    logic [PC_WIDTH-1:0] skid_pc_s;
    logic [31:0]         skid_inst_s;
    logic                slot_live_s;
    logic [PC_WIDTH-1:0] slot_pc_s;
    logic [31:0]         slot_inst_s;

    // Issue decision and read address; a redirect always issues its target.
    always_comb begin
        issue_s      = 1'b0;
        issue_addr_s = fetch_pc_r;
        if (rst) begin
            issue_s = 1'b0;
        end else begin
            issue_s = redirect_valid || (state_r == EMPTY) || !decode_stall;
        end
        if (redirect_valid) begin
            issue_addr_s = redirect_pc & ALIGN_MASK;
        end else begin
            issue_addr_s = fetch_pc_r;
        end
    end

    assign imem_req  = issue_s;
    assign imem_addr = issue_addr_s;

    // Park the in-flight response only when decode stalls on a live FETCH slot.
    always_comb begin
        skid_load_s = 1'b0;
        if (!rst && !redirect_valid && (state_r == FETCH) && decode_stall) begin
            skid_load_s = 1'b1;
        end else begin
            skid_load_s = 1'b0;
        end
    end

    fetch_skid_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load_s),
        .clear     (redirect_valid),
        .load_pc   (inflight_pc_r),
        .load_inst (imem_rdata),
        .valid     (skid_valid_s),
        .pc        (skid_pc_s),
        .inst      (skid_inst_s)
    );

    // Fetch FSM and PC registers; redirect has top priority over every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= EMPTY;
            fetch_pc_r    <= RESET_PC;
            inflight_pc_r <= RESET_PC;
        end else begin
            if (issue_s) begin
                inflight_pc_r <= issue_addr_s;
                fetch_pc_r    <= issue_addr_s + PC_STEP;
            end else begin
                inflight_pc_r <= inflight_pc_r;
                fetch_pc_r    <= fetch_pc_r;
            end
            if (redirect_valid) begin
                state_r <= FETCH;
            end else begin
                case (state_r)
                    EMPTY:   state_r <= FETCH;
                    FETCH:   state_r <= decode_stall ? HOLD : FETCH;
                    HOLD:    state_r <= decode_stall ? HOLD : FETCH;
                    default: state_r <= EMPTY;
                endcase
            end
        end
    end

    // Select the presented slot source from the current state.
    always_comb begin
        slot_live_s = 1'b0;
        slot_pc_s   = fetch_pc_r;
        slot_inst_s = INST_NOP;
        case (state_r)
            FETCH: begin
                slot_live_s = 1'b1;
                slot_pc_s   = inflight_pc_r;
                slot_inst_s = imem_rdata;
            end
            HOLD: begin
                slot_live_s = skid_valid_s;
                slot_pc_s   = skid_pc_s;
                slot_inst_s = skid_inst_s;
            end
            EMPTY: begin
                slot_live_s = 1'b0;
                slot_pc_s   = fetch_pc_r;
                slot_inst_s = INST_NOP;
            end
            default: begin
                slot_live_s = 1'b0;
                slot_pc_s   = fetch_pc_r;
                slot_inst_s = INST_NOP;
            end
        endcase
    end

    // Decode outputs: reset and redirect (wrong path) both kill the slot.
    always_comb begin
        decode_valid = 1'b0;
        decode_pc    = RESET_PC;
        decode_inst  = INST_NOP;
        if (rst) begin
            decode_valid = 1'b0;
            decode_pc    = RESET_PC;
            decode_inst  = INST_NOP;
        end else if (redirect_valid || !slot_live_s) begin
            decode_valid = 1'b0;
            decode_pc    = slot_pc_s;
            decode_inst  = INST_NOP;
        end else begin
            decode_valid = 1'b1;
            decode_pc    = slot_pc_s;
            decode_inst  = slot_inst_s;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        decode_stall;
    logic        decode_valid;
    logic [15:0] decode_pc;
    logic [31:0] decode_inst;

    // second instance exercising RESET_PC wrap
    logic        rst_w;
    logic        imem_req_w;
    logic [15:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        redirect_valid_w = 1'b0;
    logic [15:0] redirect_pc_w = 16'h0000;
    logic        decode_stall_w = 1'b0;
    logic        decode_valid_w;
    logic [15:0] decode_pc_w;
    logic [31:0] decode_inst_w;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .decode_stall(decode_stall),
        .decode_valid(decode_valid), .decode_pc(decode_pc), .decode_inst(decode_inst)
    );

    fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'hFFFC)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .redirect_valid(redirect_valid_w),
        .redirect_pc(redirect_pc_w), .decode_stall(decode_stall_w),
        .decode_valid(decode_valid_w), .decode_pc(decode_pc_w), .decode_inst(decode_inst_w)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    // Synchronous memory models: junk when no read was issued.
    always_ff @(posedge clk) begin
        imem_rdata   <= imem_req   ? mem_word(imem_addr)   : JUNK;
        imem_rdata_w <= imem_req_w ? mem_word(imem_addr_w) : JUNK;
    end

    wire [65:0] obs_full = {imem_req, imem_addr, decode_valid, decode_pc, decode_inst};
    wire [49:0] obs_ctl  = {imem_req, imem_addr, decode_valid, decode_inst};
    wire [49:0] obs_rst  = {imem_req, decode_valid, decode_pc, decode_inst};
    wire [65:0] obs_w    = {imem_req_w, imem_addr_w, decode_valid_w, decode_pc_w, decode_inst_w};

    logic [65:0] exp_full;
    logic [49:0] exp_part;

    // drive one cycle's inputs at the falling edge, then let outputs settle
    task automatic cyc(input logic r, input logic s, input logic rv, input logic [15:0] rpc);
        @(negedge clk);
        rst = r; decode_stall = s; redirect_valid = rv; redirect_pc = rpc;
        #1;
    endtask

    task automatic test_reset();
        rst_w = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 16'h0000);
            exp_part = {1'b0, 1'b0, 16'h0000, NOP};
            if (obs_rst !== exp_part) begin
                errors++; $display("FAIL reset_%0d: got %h want %h", i, obs_rst, exp_part);
            end
            checks++;
        end
    endtask

    task automatic test_stream();
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_part = {1'b1, 16'h0000, 1'b0, NOP};
        if (obs_ctl !== exp_part) begin
            errors++; $display("FAIL stream_c0: got %h want %h", obs_ctl, exp_part);
        end
        checks++;
        for (int i = 1; i <= 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            exp_full = {1'b1, 16'(4*i), 1'b1, 16'(4*(i-1)), mem_word(16'(4*(i-1)))};
            if (obs_full !== exp_full) begin
                errors++; $display("FAIL stream_c%0d: got %h want %h", i, obs_full, exp_full);
            end
            checks++;
        end
    endtask

    task automatic test_stall();
        // pc=8 presented for 3 stalled cycles, skid must hide memory junk
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'h0000);
            exp_full = {1'b0, 16'h000C, 1'b1, 16'h0008, mem_word(16'h0008)};
            if (obs_full !== exp_full) begin
                errors++; $display("FAIL stall_%0d: got %h want %h", i, obs_full, exp_full);
            end
            checks++;
        end
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_full = {1'b1, 16'h000C, 1'b1, 16'h0008, mem_word(16'h0008)};
        if (obs_full !== exp_full) begin
            errors++; $display("FAIL stall_release: got %h want %h", obs_full, exp_full);
        end
        checks++;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_full = {1'b1, 16'h0010, 1'b1, 16'h000C, mem_word(16'h000C)};
        if (obs_full !== exp_full) begin
            errors++; $display("FAIL stall_nobubble: got %h want %h", obs_full, exp_full);
        end
        checks++;
    endtask

    task automatic test_redirect();
        cyc(1'b0, 1'b0, 1'b1, 16'h0100);
        exp_part = {1'b1, 16'h0100, 1'b0, NOP};
        if (obs_ctl !== exp_part) begin
            errors++; $display("FAIL redirect_squash: got %h want %h", obs_ctl, exp_part);
        end
        checks++;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 16'h0000);
            exp_full = {1'b1, 16'(16'h0104 + 4*i), 1'b1, 16'(16'h0100 + 4*i), mem_word(16'(16'h0100 + 4*i))};
            if (obs_full !== exp_full) begin
                errors++; $display("FAIL redirect_target_%0d: got %h want %h", i, obs_full, exp_full);
            end
            checks++;
        end
    endtask

    task automatic test_redirect_hold();
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        exp_full = {1'b0, 16'h010C, 1'b1, 16'h0108, mem_word(16'h0108)};
        if (obs_full !== exp_full) begin
            errors++; $display("FAIL rhold_stall: got %h want %h", obs_full, exp_full);
        end
        checks++;
        cyc(1'b0, 1'b1, 1'b1, 16'h0200);
        exp_part = {1'b1, 16'h0200, 1'b0, NOP};
        if (obs_ctl !== exp_part) begin
            errors++; $display("FAIL rhold_redirect: got %h want %h", obs_ctl, exp_part);
        end
        checks++;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_full = {1'b1, 16'h0204, 1'b1, 16'h0200, mem_word(16'h0200)};
        if (obs_full !== exp_full) begin
            errors++; $display("FAIL rhold_target: got %h want %h", obs_full, exp_full);
        end
        checks++;
    endtask

    task automatic test_misaligned();
        cyc(1'b0, 1'b0, 1'b1, 16'h0102);
        exp_part = {1'b1, 16'h0100, 1'b0, NOP};
        if (obs_ctl !== exp_part) begin
            errors++; $display("FAIL misalign_addr: got %h want %h", obs_ctl, exp_part);
        end
        checks++;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_full = {1'b1, 16'h0104, 1'b1, 16'h0100, mem_word(16'h0100)};
        if (obs_full !== exp_full) begin
            errors++; $display("FAIL misalign_pc: got %h want %h", obs_full, exp_full);
        end
        checks++;
    endtask

    task automatic test_reset_in_hold();
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        cyc(1'b0, 1'b1, 1'b0, 16'h0000);
        exp_full = {1'b0, 16'h0108, 1'b1, 16'h0104, mem_word(16'h0104)};
        if (obs_full !== exp_full) begin
            errors++; $display("FAIL rih_hold: got %h want %h", obs_full, exp_full);
        end
        checks++;
        cyc(1'b1, 1'b1, 1'b0, 16'h0000);
        exp_part = {1'b0, 1'b0, 16'h0000, NOP};
        if (obs_rst !== exp_part) begin
            errors++; $display("FAIL rih_in_reset: got %h want %h", obs_rst, exp_part);
        end
        checks++;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_part = {1'b1, 16'h0000, 1'b0, NOP};
        if (obs_ctl !== exp_part) begin
            errors++; $display("FAIL rih_after: got %h want %h", obs_ctl, exp_part);
        end
        checks++;
        cyc(1'b0, 1'b0, 1'b0, 16'h0000);
        exp_full = {1'b1, 16'h0004, 1'b1, 16'h0000, mem_word(16'h0000)};
        if (obs_full !== exp_full) begin
            errors++; $display("FAIL rih_restart: got %h want %h", obs_full, exp_full);
        end
        checks++;
    endtask

    task automatic test_wrap();
        logic [15:0] addrs [4];
        addrs[0] = 16'hFFFC; addrs[1] = 16'h0000; addrs[2] = 16'h0004; addrs[3] = 16'h0008;
        @(negedge clk);
        rst_w = 1'b0;
        #1;
        exp_full = {1'b1, 16'hFFFC, 1'b0, 16'hFFFC, NOP};
        if (obs_w[65:32] !== exp_full[65:32] || decode_inst_w !== NOP) begin
            errors++; $display("FAIL wrap_c0: got %h want %h", obs_w, exp_full);
        end
        checks++;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            #1;
            exp_full = {1'b1, addrs[i], 1'b1, addrs[i-1], mem_word(addrs[i-1])};
            if (obs_w !== exp_full) begin
                errors++; $display("FAIL wrap_c%0d: got %h want %h", i, obs_w, exp_full);
            end
            checks++;
        end
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        decode_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_hold();
        test_misaligned();
        test_reset_in_hold();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
